// File: rtl/falafel_mem_responder.sv
// Memory-side responder for the falafel allocator: one read/write/CAS at a time with a programmable response latency.
// Optional FALAFEL_MEM_RESP_BOUNDS_EN adds address range checking and the sticky oob_err_o output.
module falafel_mem_responder #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2,
  parameter int WRITE_RESP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_resp_val_o,
  input  logic              mem_resp_rdy_i,
  output logic [DATA_W-1:0] mem_resp_data_o
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
  ,
  output logic              oob_err_o
`endif
);

  localparam int OFF_W    = $clog2(DATA_W / 8);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_LOAD = (LATENCY > 0) ? (LATENCY - 1) : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_silent;
  logic                r_resp_val;
  logic [DATA_W-1:0]   r_resp_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_old;
  logic                w_is_wr;
  logic                w_is_cas;
  logic                w_cas_hit;
  logic                w_silent;
  logic                w_oob;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;

  assign w_accept  = mem_req_val_i && (r_state == S_IDLE) && !rst_i;
  assign w_idx     = mem_req_addr_i[OFF_W +: IDX_W];
  assign w_old     = r_mem[w_idx];
  assign w_is_wr   = mem_req_is_write_i && !mem_req_is_cas_i;
  assign w_is_cas  = mem_req_is_write_i && mem_req_is_cas_i;
  assign w_cas_hit = w_is_cas && (w_old == mem_req_cas_exp_i);
  assign w_silent  = w_is_wr && (WRITE_RESP == 0);

`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
  logic [DATA_W-1:0] w_word_addr;
  logic              r_oob;

  assign w_word_addr = mem_req_addr_i >> OFF_W;
  assign w_oob       = (w_word_addr >= DATA_W'(DEPTH));
  assign oob_err_o   = r_oob;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_oob <= 1'b0;
    end else if (w_accept && w_oob) begin
      r_oob <= 1'b1;
    end
  end
`else
  assign w_oob = 1'b0;
`endif

  // The whole read-modify-write happens on the accept edge, so a CAS is atomic.
  assign w_we    = w_accept && !w_oob && (w_is_wr || w_cas_hit);
  assign w_rdata = w_is_wr ? '0 : (w_oob ? '1 : w_old);

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_idx] <= mem_req_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_silent    <= 1'b0;
      r_resp_val  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_resp_data <= w_rdata;
            r_silent    <= w_silent;
            if (LATENCY > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_W'(LAT_LOAD);
            end else if (!w_silent) begin
              r_state    <= S_RESP;
              r_resp_val <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_silent) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_RESP;
              r_resp_val <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // Hold data and valid until the requester takes the response.
          if (mem_resp_rdy_i) begin
            r_state    <= S_IDLE;
            r_resp_val <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_resp_val <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_rdy_o   = (r_state == S_IDLE);
  assign mem_resp_val_o  = r_resp_val;
  assign mem_resp_data_o = r_resp_data;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Scoreboard bench for falafel_mem_responder: instance 0 uses LATENCY=2/WRITE_RESP=1, instance 1 LATENCY=0/WRITE_RESP=0.
module tb_falafel_mem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_val    [2];
  logic        req_rdy    [2];
  logic        req_wr     [2];
  logic        req_cas    [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_data   [2];
  logic [63:0] req_exp    [2];
  logic        resp_val   [2];
  logic        resp_rdy   [2];
  logic [63:0] resp_data  [2];
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
  logic        oob_err    [2];
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  falafel_mem_responder #(.DATA_W(64), .DEPTH(256), .LATENCY(2), .WRITE_RESP(1)) u_dut (
    .clk_i(clk), .rst_i(rst[0]),
    .mem_req_val_i(req_val[0]), .mem_req_rdy_o(req_rdy[0]),
    .mem_req_is_write_i(req_wr[0]), .mem_req_is_cas_i(req_cas[0]),
    .mem_req_addr_i(req_addr[0]), .mem_req_data_i(req_data[0]), .mem_req_cas_exp_i(req_exp[0]),
    .mem_resp_val_o(resp_val[0]), .mem_resp_rdy_i(resp_rdy[0]), .mem_resp_data_o(resp_data[0])
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
    , .oob_err_o(oob_err[0])
`endif
  );

  falafel_mem_responder #(.DATA_W(64), .DEPTH(256), .LATENCY(0), .WRITE_RESP(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[1]),
    .mem_req_val_i(req_val[1]), .mem_req_rdy_o(req_rdy[1]),
    .mem_req_is_write_i(req_wr[1]), .mem_req_is_cas_i(req_cas[1]),
    .mem_req_addr_i(req_addr[1]), .mem_req_data_i(req_data[1]), .mem_req_cas_exp_i(req_exp[1]),
    .mem_resp_val_o(resp_val[1]), .mem_resp_rdy_i(resp_rdy[1]), .mem_resp_data_o(resp_data[1])
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
    , .oob_err_o(oob_err[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns at a negedge with the responder idle again.
  task automatic do_req(input int s, input bit wr, input bit cas, input logic [63:0] addr,
                        input logic [63:0] data, input logic [63:0] exp_v, input bit want_resp,
                        input logic [63:0] want_data, input int lat, input int hold);
    int          n;
    logic [63:0] held;
    logic [63:0] exp_d;
    resp_rdy[s] = (hold == 0);
    req_wr[s]   = wr;
    req_cas[s]  = cas;
    req_addr[s] = addr;
    req_data[s] = data;
    req_exp[s]  = exp_v;
    req_val[s]  = 1'b1;
    n = 0;
    while (!req_rdy[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(req_rdy[s]), 64'd1);
    @(negedge clk);
    req_val[s]  = 1'b0;
    req_addr[s] = {$urandom, $urandom};
    req_data[s] = {$urandom, $urandom};
    req_exp[s]  = {$urandom, $urandom};
    if (want_resp) begin
      sb_q.push_back(want_data);
      n = 1;
      while (!resp_val[s] && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("latency", 64'(n), 64'(lat + 1));
      held = resp_data[s];
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_val", 64'(resp_val[s]), 64'd1);
        chk("bp_data", resp_data[s], held);
        chk("bp_req_rdy", 64'(req_rdy[s]), 64'd0);
      end
      resp_rdy[s] = 1'b1;
      exp_d = sb_q.pop_front();
      chk("resp_data", resp_data[s], exp_d);
      $display("txn dut%0d wr=%0d cas=%0d addr=%h data=%h lat=%0d", s, wr, cas, addr, resp_data[s], n - 1);
      @(negedge clk);
      chk("post_resp_val", 64'(resp_val[s]), 64'd0);
      chk("post_req_rdy", 64'(req_rdy[s]), 64'd1);
    end else begin
      for (int i = 0; i < lat + 3; i++) begin
        chk("silent_no_resp", 64'(resp_val[s]), 64'd0);
        @(negedge clk);
      end
      chk("silent_req_rdy", 64'(req_rdy[s]), 64'd1);
      $display("txn dut%0d silent write addr=%h data=%h", s, addr, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_d;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req_val[s] = 1'b0; req_wr[s] = 1'b0; req_cas[s] = 1'b0;
      req_addr[s] = '0; req_data[s] = '0; req_exp[s] = '0; resp_rdy[s] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_rdy", 64'(req_rdy[s]), 64'd1);
      chk("rst_resp_val", 64'(resp_val[s]), 64'd0);
      chk("rst_resp_data", resp_data[s], 64'd0);
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
      chk("rst_oob", 64'(oob_err[s]), 64'd0);
`endif
    end

    // Plain write then read, LATENCY=2
    do_req(0, 1, 0, 64'h40, 64'h1234, 64'h0, 1, 64'h0, 2, 0);
    do_req(0, 0, 0, 64'h40, 64'h0, 64'h0, 1, 64'h1234, 2, 0);
    // CAS success, then failing CAS leaves memory alone
    do_req(0, 1, 1, 64'h40, 64'h99, 64'h1234, 1, 64'h1234, 2, 0);
    do_req(0, 0, 0, 64'h40, 64'h0, 64'h0, 1, 64'h99, 2, 0);
    do_req(0, 1, 1, 64'h40, 64'h7, 64'h1234, 1, 64'h99, 2, 0);
    // Low byte-offset bits ignored; backpressure held for 5 cycles
    do_req(0, 0, 0, 64'h45, 64'h0, 64'h0, 1, 64'h99, 2, 5);

    // LATENCY=0, silent writes, then back-to-back reads with val held
    do_req(1, 1, 0, 64'h0, 64'hA0, 64'h0, 0, 64'h0, 0, 0);
    do_req(1, 1, 0, 64'h8, 64'hB8, 64'h0, 0, 64'h0, 0, 0);
    resp_rdy[1] = 1'b1; req_wr[1] = 1'b0; req_cas[1] = 1'b0;
    req_addr[1] = 64'h0; req_val[1] = 1'b1;
    sb_q.push_back(64'hA0);
    sb_q.push_back(64'hB8);
    @(negedge clk);
    chk("b2b_first_val", 64'(resp_val[1]), 64'd1);
    exp_d = sb_q.pop_front();
    chk("b2b_first_data", resp_data[1], exp_d);
    chk("b2b_busy_rdy", 64'(req_rdy[1]), 64'd0);
    req_addr[1] = 64'h8;
    @(negedge clk);
    chk("b2b_turn_rdy", 64'(req_rdy[1]), 64'd1);
    chk("b2b_turn_val", 64'(resp_val[1]), 64'd0);
    @(negedge clk);
    req_val[1] = 1'b0;
    chk("b2b_second_val", 64'(resp_val[1]), 64'd1);
    exp_d = sb_q.pop_front();
    chk("b2b_second_data", resp_data[1], exp_d);
    $display("txn dut1 back-to-back reads done");
    @(negedge clk);
    chk("b2b_idle", 64'(req_rdy[1]), 64'd1);

    // Reset while in WAIT: response dropped, write stays committed
    resp_rdy[0] = 1'b1; req_wr[0] = 1'b1; req_cas[0] = 1'b0;
    req_addr[0] = 64'h10; req_data[0] = 64'h55; req_val[0] = 1'b1;
    @(negedge clk);
    req_val[0] = 1'b0;
    chk("wait_busy", 64'(req_rdy[0]), 64'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort_rdy", 64'(req_rdy[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 64'(resp_val[0]), 64'd0);
      @(negedge clk);
    end
    $display("txn dut0 reset during WAIT");
    do_req(0, 0, 0, 64'h10, 64'h0, 64'h0, 1, 64'h55, 2, 0);

    // Address above DEPTH words
    do_req(0, 1, 0, 64'h0, 64'hC0DE, 64'h0, 1, 64'h0, 2, 0);
`ifdef FALAFEL_MEM_RESP_BOUNDS_EN
    do_req(0, 0, 0, 64'h800, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    chk("oob_sticky", 64'(oob_err[0]), 64'd1);
    do_req(0, 1, 0, 64'h800, 64'h77, 64'h0, 1, 64'h0, 2, 0);
    do_req(0, 0, 0, 64'h0, 64'h0, 64'h0, 1, 64'hC0DE, 2, 0);
    chk("oob_other_inst", 64'(oob_err[1]), 64'd0);
`else
    do_req(0, 0, 0, 64'h800, 64'h0, 64'h0, 1, 64'hC0DE, 2, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/falafel_mem_responder.md
Name: falafel_mem_responder

Overview:
- Memory-side responder for the falafel allocator's memory request/response channel.
- Accepts one read, write or compare-and-swap (CAS) at a time, performs it atomically on an internal word-addressed array, and returns the response after a programmable latency.
- Used as the backing heap in simulation and FPGA bring-up. Sits directly on the allocator's mem_req_*/mem_resp_* ports.

Parameters:
- DATA_W, 64: word and address width; must be a power of two, at least 16.
- DEPTH, 256: number of words in the array; must be a power of two.
- LATENCY, 2: extra cycles between request accept and response valid; 0 is legal.
- WRITE_RESP, 1: 1 means plain writes return a response with data 0; 0 means plain writes return no response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_req_val_i  in  1  request valid
- mem_req_rdy_o  out  1  responder ready to accept a request
- mem_req_is_write_i  in  1  1 = write or CAS, 0 = read
- mem_req_is_cas_i  in  1  with is_write=1: 1 = CAS, 0 = plain write; ignored on reads
- mem_req_addr_i  in  DATA_W  byte address
- mem_req_data_i  in  DATA_W  write data / CAS new value
- mem_req_cas_exp_i  in  DATA_W  CAS expected value
- mem_resp_val_o  out  1  response valid
- mem_resp_rdy_i  in  1  requester ready for the response
- mem_resp_data_o  out  DATA_W  response data

Behaviour:
- Reset state: IDLE, mem_req_rdy_o=1, mem_resp_val_o=0, mem_resp_data_o=0, latency counter=0. Array contents are not reset.
- Word index: idx = addr[log2(DATA_W/8) +: log2(DEPTH)]. Low byte-offset bits are ignored.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - mem_req_rdy_o = (state==IDLE).
  - Accept happens on the edge where val && rdy, at cycle T.
- The operation executes on the accept edge T, so it is atomic with respect to later requests:
  - READ: resp_data <= mem[idx].
  - WRITE: mem[idx] <= data; resp_data <= 0.
  - CAS: resp_data <= mem[idx] (old value); if mem[idx]==cas_exp then mem[idx] <= data. The requester detects success by comparing the returned value with cas_exp.
- After accept:
  - LATENCY>0: go to WAIT and load the counter with LATENCY-1. Decrement each cycle; when the counter reaches 0, go to RESP.
  - LATENCY==0: go straight to RESP. mem_resp_val_o rises at T+1.
  - General case: mem_resp_val_o rises at T+1+LATENCY.
- RESP:
  - mem_resp_val_o=1 and mem_resp_data_o stays stable until mem_resp_rdy_i.
  - On the handshake edge, go to IDLE. rdy_o=1 the following cycle; there is no same-cycle turnaround.
- WRITE with WRITE_RESP=0: after the latency, go to IDLE without asserting mem_resp_val_o.
- mem_resp_rdy_i held high in advance: handshake completes in the first RESP cycle.
- Request inputs are sampled only at accept. Changes while busy are ignored.
- Reset mid-operation:
  - Aborts to IDLE and drops any pending response.
  - A write or CAS that was already accepted stays committed in the array.

Optional Feature:
- Macro FALAFEL_MEM_RESP_BOUNDS_EN.
- Defined:
  - Address check: in range iff (addr >> log2(DATA_W/8)) < DEPTH.
  - Out-of-range READ or CAS returns all-ones. Out-of-range WRITE or CAS does not modify the array.
  - Adds output port oob_err_o (1 bit), reset to 0, sticky-set on any out-of-range accept and cleared only by rst_i.
  - Latency and handshake are unchanged.
- Undefined: upper address bits are ignored, so addresses wrap modulo DEPTH words. No oob_err_o port.

Test Plan:
1. Write 0x1234 to addr 0x40, then read 0x40 -> write response data 0 at accept+3; read response data 0x1234 at accept+3 (LATENCY=2).
2. mem[0x40]=0x1234. CAS exp=0x1234, new=0x99, then read -> CAS returns 0x1234; read returns 0x99. Second CAS exp=0x1234, new=0x7 -> returns 0x99; memory stays 0x99.
3. Response backpressure: hold mem_resp_rdy_i=0 for 5 cycles -> resp_val stays 1, data stable, req_rdy_o=0 throughout. Raise rdy -> req_rdy_o=1 one cycle after the handshake.
4. LATENCY=0, back-to-back reads of 0x0 and 0x8 with val held high -> responses at accept+1. Second accept occurs 1 cycle after the first response handshake.
5. Assert rst_i while in WAIT after a write of 0x55 to 0x10 -> resp_val never rises, rdy_o=1 next cycle; a later read of 0x10 returns 0x55.
6. With FALAFEL_MEM_RESP_BOUNDS_EN, DEPTH=256, read addr 0x800 -> response 0xFFFF_FFFF_FFFF_FFFF and oob_err_o=1. Without the macro, the same read returns mem[0].
